// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI peripheral: control/config registers, a W1C
// interrupt status fed by hardware events, a write counter and a synchronised input.
module spi_reg_bank #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wr_rdn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
  input  logic              we,
  output logic [REG_W-1:0]  rdata,
  output logic [7:0]        status,
  input  logic [5:0]        hw_event,
  input  logic [REG_W-1:0]  hw_in,
  output logic [REG_W-1:0]  ctrl_o,
  output logic [REG_W-1:0]  cfg_a,
  output logic [REG_W-1:0]  cfg_b,
  output logic              irq
);

  localparam int NUM_LOC    = 2 ** ADDR_W;
  localparam int NUM_MAPPED = 8;

  localparam int A_CTRL       = 0;
  localparam int A_IRQ_MASK   = 1;
  localparam int A_IRQ_STATUS = 2;
  localparam int A_SCRATCH    = 3;
  localparam int A_WR_COUNT   = 4;
  localparam int A_HW_IN      = 5;
  localparam int A_CFG_A      = 6;
  localparam int A_CFG_B      = 7;

  // One bit per mapped address: which accept writes, and which obey the lock bit.
  localparam logic [NUM_MAPPED-1:0] WRITABLE = 8'b1100_1111;
  localparam logic [NUM_MAPPED-1:0] LOCKABLE = 8'b1100_1010;

  logic [REG_W-1:0] ctrl_reg;
  logic [REG_W-1:0] irq_mask_reg;
  logic [5:0]       irq_status_reg;
  logic [5:0]       irq_status_next;
  logic [REG_W-1:0] scratch_reg;
  logic [REG_W-1:0] wr_count_reg;
  logic [REG_W-1:0] hw_sync1_reg;
  logic [REG_W-1:0] hw_sync2_reg;
  logic [REG_W-1:0] cfg_a_reg;
  logic [REG_W-1:0] cfg_b_reg;
  logic [REG_W-1:0] rdata_reg;
  logic             irq_reg;

  logic             locked;
  logic [NUM_MAPPED-1:0] wr_en;
  logic             wr_accept;
  logic [5:0]       w1c_clear;
  logic [REG_W-1:0] mapped_vals [NUM_MAPPED];
  logic [REG_W-1:0] read_vals   [NUM_LOC];

  // wr_rdn is carried for monitoring only; writes are qualified by we alone.
  logic unused_wr_rdn;
  assign unused_wr_rdn = wr_rdn;

  assign locked = ctrl_reg[7];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MAPPED; gi++) begin : g_wr_decode
      assign wr_en[gi] = we & ena & (addr == ADDR_W'(gi)) & WRITABLE[gi]
                         & ~(LOCKABLE[gi] & locked);
    end
  endgenerate

  assign wr_accept = |wr_en;
  assign w1c_clear = wr_en[A_IRQ_STATUS] ? wdata[5:0] : 6'b0;

  // A hardware event beats a simultaneous W1C clear of the same bit.
  assign irq_status_next = (irq_status_reg & ~w1c_clear) | hw_event;

  always_comb begin
    mapped_vals[A_CTRL]       = ctrl_reg;
    mapped_vals[A_IRQ_MASK]   = irq_mask_reg;
    mapped_vals[A_IRQ_STATUS] = {{(REG_W-6){1'b0}}, irq_status_reg};
    mapped_vals[A_SCRATCH]    = scratch_reg;
    mapped_vals[A_WR_COUNT]   = wr_count_reg;
    mapped_vals[A_HW_IN]      = hw_sync2_reg;
    mapped_vals[A_CFG_A]      = cfg_a_reg;
    mapped_vals[A_CFG_B]      = cfg_b_reg;
  end

  generate
    for (gi = 0; gi < NUM_LOC; gi++) begin : g_rd_map
      if (gi < NUM_MAPPED) begin : g_mapped
        assign read_vals[gi] = mapped_vals[gi];
      end else begin : g_unmapped
        assign read_vals[gi] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg     <= '0;
      irq_mask_reg <= '0;
      scratch_reg  <= '0;
      cfg_a_reg    <= '0;
      cfg_b_reg    <= '0;
    end else begin
      if (wr_en[A_CTRL])     ctrl_reg     <= wdata;
      if (wr_en[A_IRQ_MASK]) irq_mask_reg <= wdata;
      if (wr_en[A_SCRATCH])  scratch_reg  <= wdata;
      if (wr_en[A_CFG_A])    cfg_a_reg    <= wdata;
      if (wr_en[A_CFG_B])    cfg_b_reg    <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_status_reg <= '0;
      wr_count_reg   <= '0;
    end else if (ena) begin
      irq_status_reg <= irq_status_next;
      if (wr_accept) wr_count_reg <= wr_count_reg + REG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hw_sync1_reg <= '0;
      hw_sync2_reg <= '0;
    end else if (ena) begin
      hw_sync1_reg <= hw_in;
      hw_sync2_reg <= hw_sync1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
      irq_reg   <= 1'b0;
    end else if (ena) begin
      rdata_reg <= read_vals[addr];
      irq_reg   <= ctrl_reg[0] & |(irq_status_reg & irq_mask_reg[5:0]);
    end
  end

  assign rdata  = rdata_reg;
  assign irq    = irq_reg;
  assign ctrl_o = ctrl_reg;
  assign cfg_a  = cfg_a_reg;
  assign cfg_b  = cfg_b_reg;
  assign status = {ctrl_reg[7], irq_reg, irq_status_reg};

endmodule
